// File: rtl/shift_word_feeder_pkg.sv
// Shared definitions for the parallel-to-serial feeder and the bidirectional shift register it drives.
// The direction constants match the shift register's dir input encoding.
package shift_word_feeder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } feeder_state_e;

  localparam logic DIR_TOWARD_MSB = 1'b0;
  localparam logic DIR_TOWARD_LSB = 1'b1;

endpackage

// File: rtl/shift_word_feeder.sv
// Serialises one MSB-bit word per valid/ready handshake onto the d/en/dir interface of the
// downstream bidirectional shift register, so that register ends up holding the word unchanged.
module shift_word_feeder
  import shift_word_feeder_pkg::*;
#(
  parameter int MSB = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [MSB-1:0] in_data,
  input  logic           in_dir,
  input  logic           hold,
  output logic           sr_d,
  output logic           sr_en,
  output logic           sr_dir,
  output logic           busy,
  output logic           word_done
);

  localparam int              CW       = (MSB > 1) ? $clog2(MSB) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(MSB - 1);

  feeder_state_e  state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [MSB-1:0] shadow_q, shadow_d;
  logic           dir_q, dir_d;
  logic           sr_d_q, sr_d_d;
  logic           sr_en_q, sr_en_d;
  logic           sr_dir_q, sr_dir_d;
  logic           busy_q, busy_d;
  logic           word_done_q, word_done_d;
  logic           last_q, last_d;
  logic           accept;

  // Toward MSB the register needs the top bit first; toward LSB it needs bit 0 first.
  function automatic logic pick_bit(input logic [MSB-1:0] word, input logic dir,
                                    input logic [CW-1:0] idx);
    if (dir == DIR_TOWARD_LSB) begin
      pick_bit = word[idx];
    end else begin
      pick_bit = word[CNT_LAST - idx];
    end
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      dir_q       <= 1'b0;
      sr_d_q      <= 1'b0;
      sr_en_q     <= 1'b0;
      sr_dir_q    <= 1'b0;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      dir_q       <= dir_d;
      sr_d_q      <= sr_d_d;
      sr_en_q     <= sr_en_d;
      sr_dir_q    <= sr_dir_d;
      busy_q      <= busy_d;
      word_done_q <= word_done_d;
      last_q      <= last_d;
    end
  end

  // Handshake and next state; a new word can only replace one whose last bit leaves this edge
  always_comb begin
    in_ready = 1'b0;
    state_d  = state_q;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      SHIFT:   in_ready = (cnt_q == CNT_LAST) && !hold;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid && in_ready;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (!hold && (cnt_q == CNT_LAST)) begin
          state_d = accept ? SHIFT : IDLE;
        end else begin
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; cnt is the index of the next bit to put on sr_d
  always_comb begin
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    dir_d       = dir_q;
    sr_d_d      = sr_d_q;
    sr_dir_d    = sr_dir_q;
    sr_en_d     = 1'b0;
    last_d      = 1'b0;
    word_done_d = last_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shadow_d = in_data;
          dir_d    = in_dir;
          if (!hold) begin
            sr_en_d  = 1'b1;
            sr_d_d   = pick_bit(in_data, in_dir, CW'(0));
            sr_dir_d = in_dir;
            cnt_d    = CW'(1);
          end else begin
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      SHIFT: begin
        if (!hold) begin
          sr_en_d  = 1'b1;
          sr_d_d   = pick_bit(shadow_q, dir_q, cnt_q);
          sr_dir_d = dir_q;
          if (cnt_q == CNT_LAST) begin
            last_d = 1'b1;
            cnt_d  = '0;
            if (accept) begin
              shadow_d = in_data;
              dir_d    = in_dir;
            end else begin
              shadow_d = shadow_q;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
    busy_d = (state_d == SHIFT) || last_d;
  end

  assign sr_d      = sr_d_q;
  assign sr_en     = sr_en_q;
  assign sr_dir    = sr_dir_q;
  assign busy      = busy_q;
  assign word_done = word_done_q;

endmodule

// File: tb/tb_shift_word_feeder.sv
// Scoreboard bench: expected bits and words are queued at handshake time from the bit-order rule,
// and a negedge monitor checks the serial stream and a behavioural downstream register at word_done.
module tb_shift_word_feeder;
  import shift_word_feeder_pkg::*;

  localparam int MSB = 8;

  typedef struct packed {
    logic d;
    logic dir;
  } exp_bit_t;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           in_valid = 1'b0;
  logic [MSB-1:0] in_data = '0;
  logic           in_dir = 1'b0;
  logic           hold = 1'b0;
  logic           in_ready, sr_d, sr_en, sr_dir, busy, word_done;

  logic [MSB-1:0] ds_q = '0;
  exp_bit_t       bit_q[$];
  logic [MSB-1:0] word_q[$];
  exp_bit_t       mon_e;
  logic [MSB-1:0] mon_w;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0;
  int en_total = 0, done_total = 0, gap_total = 0;
  bit rand_hold = 1'b0;

  shift_word_feeder #(.MSB(MSB)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dir(in_dir), .hold(hold),
    .sr_d(sr_d), .sr_en(sr_en), .sr_dir(sr_dir), .busy(busy), .word_done(word_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural downstream bidirectional shift register (not reset by the feeder's reset)
  always @(posedge clk) begin
    if (sr_en === 1'b1) begin
      if (sr_dir == DIR_TOWARD_LSB) ds_q <= {sr_d, ds_q[MSB-1:1]};
      else                          ds_q <= {ds_q[MSB-2:0], sr_d};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a shift or a word completion
  always @(negedge clk) begin
    if (sr_en === 1'b1) begin
      en_total++;
      if (bit_q.size() == 0) begin
        chk("unexpected_sr_en", sr_en, 0);
      end else begin
        mon_e = bit_q.pop_front();
        chk("sr_d", sr_d, mon_e.d);
        chk("sr_dir", sr_dir, mon_e.dir);
      end
    end else if (busy === 1'b1) begin
      gap_total++;
    end
    if (word_done === 1'b1) begin
      done_total++;
      if (word_q.size() == 0) begin
        chk("unexpected_word_done", word_done, 0);
      end else begin
        mon_w = word_q.pop_front();
        chk("word_value", ds_q, mon_w);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    if (rand_hold) hold = ($urandom_range(0, 3) == 0);
  endtask

  // Offer a word, wait (bounded) for the handshake, queue its expected bit stream
  task automatic send(input logic [MSB-1:0] data, input logic dir);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_dir   = dir;
    #1;
    while (in_ready !== 1'b1 && guard < 100) begin
      step();
      #1;
      guard++;
    end
    if (in_ready !== 1'b1) begin
      chk("send_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      for (int i = 0; i < MSB; i++) begin
        bit_q.push_back('{d: (dir ? data[i] : data[MSB-1-i]), dir: dir});
      end
      word_q.push_back(data);
      acc_cyc = cyc + 1;
      @(posedge clk);
      step();
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_done(output int lat);
    int g = 0;
    while (word_done !== 1'b1 && g < 200) begin
      step();
      g++;
    end
    chk("done_timeout", word_done, 1);
    lat = cyc - acc_cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, en0, g0, d0, first, g;

    // Reset state
    repeat (2) step();
    #1;
    chk("rst_sr_d", sr_d, 0);
    chk("rst_sr_en", sr_en, 0);
    chk("rst_sr_dir", sr_dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word_done", word_done, 0);
    chk("rst_in_ready", in_ready, 1);
    rstn = 1'b1;
    step();

    // 0xA5 toward MSB, no hold
    en0 = en_total; g0 = gap_total;
    send(8'hA5, DIR_TOWARD_MSB);
    chk("busy_after_accept", busy, 1);
    wait_done(lat);
    chk("a5_latency", lat, MSB);
    #1;
    chk("a5_en_cycles", en_total - en0, MSB);
    chk("a5_gap_cycles", gap_total - g0, 0);
    chk("a5_busy_at_done", busy, 0);
    chk("a5_downstream", ds_q, 8'hA5);

    // 0x3C toward LSB
    step();
    send(8'h3C, DIR_TOWARD_LSB);
    wait_done(lat);
    chk("3c_latency", lat, MSB);
    chk("3c_downstream", ds_q, 8'h3C);

    // Back-to-back words with alternating direction
    step(); #1;
    en0 = en_total; d0 = done_total; g0 = gap_total;
    send(8'h01, DIR_TOWARD_MSB);
    first = acc_cyc;
    send(8'h80, DIR_TOWARD_LSB);
    send(8'hFF, DIR_TOWARD_MSB);
    g = 0;
    while (done_total - d0 < 3 && g < 200) begin
      step(); #1; g++;
    end
    chk("b2b_done_pulses", done_total - d0, 3);
    chk("b2b_span", cyc - first, 3 * MSB);
    chk("b2b_en_cycles", en_total - en0, 3 * MSB);
    chk("b2b_gap_cycles", gap_total - g0, 0);

    // 0x96 with hold high for three cycles after bit 2
    step(); #1;
    en0 = en_total; g0 = gap_total;
    send(8'h96, DIR_TOWARD_MSB);
    step(); step();
    hold = 1'b1;
    repeat (3) step();
    hold = 1'b0;
    wait_done(lat);
    chk("hold_latency", lat, MSB + 3);
    #1;
    chk("hold_gap_cycles", gap_total - g0, 3);
    chk("hold_en_cycles", en_total - en0, MSB);
    chk("hold_downstream", ds_q, 8'h96);

    // Reset after bit 4 of 0xF0, then 0x0F must complete
    step();
    send(8'hF0, DIR_TOWARD_MSB);
    repeat (4) step();
    rstn = 1'b0;
    step();
    #1;
    chk("midrst_sr_d", sr_d, 0);
    chk("midrst_sr_en", sr_en, 0);
    chk("midrst_sr_dir", sr_dir, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_word_done", word_done, 0);
    chk("midrst_in_ready", in_ready, 1);
    bit_q.delete();
    word_q.delete();
    rstn = 1'b1;
    step();
    send(8'h0F, DIR_TOWARD_MSB);
    wait_done(lat);
    chk("post_rst_latency", lat, MSB);
    chk("post_rst_downstream", ds_q, 8'h0F);

    // Hold high in IDLE: the word is still accepted, shifting waits for hold to drop
    step();
    hold = 1'b1;
    #1;
    chk("idle_hold_ready", in_ready, 1);
    send(8'h5A, DIR_TOWARD_LSB);
    chk("idle_hold_no_shift0", sr_en, 0);
    step();
    chk("idle_hold_no_shift1", sr_en, 0);
    hold = 1'b0;
    wait_done(lat);
    chk("idle_hold_latency", lat, MSB + 2);
    chk("idle_hold_downstream", ds_q, 8'h5A);

    // Randomised words, gaps and hold
    step();
    rand_hold = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) step();
      send(MSB'($urandom), 1'($urandom_range(0, 1)));
    end
    rand_hold = 1'b0;
    hold = 1'b0;
    g = 0;
    while ((bit_q.size() != 0 || word_q.size() != 0) && g < 500) begin
      step(); #1; g++;
    end
    chk("rand_bits_drained", bit_q.size(), 0);
    chk("rand_words_drained", word_q.size(), 0);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
